// File: rtl/tdc_uart_framer_if.sv
// Handshake bundle between the TDC measurement core and the UART framer.
// The core drives the measurement word and strobe; the framer returns ready/busy.
interface tdc_uart_framer_if;
  logic [15:0] meas_data;
  logic        meas_valid;
  logic        meas_ready;
  logic        busy;

  modport master (output meas_data, meas_valid, input meas_ready, busy);
  modport slave  (input meas_data, meas_valid, output meas_ready, busy);
endinterface

// File: rtl/tdc_uart_framer.sv
// Serialises each accepted 16-bit TDC measurement as a 4-byte 8N1 frame:
// sync, data MSB, data LSB, count of measurements dropped since the last accept.
//
// state  | meaning
// S_IDLE | waiting for meas_valid, uart_tx idle high, meas_ready=1
// S_SEND | shifting the frame out, byte 0..3, bit 0..9, baud 0..CLKS_PER_BIT-1
module tdc_uart_framer #(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  tdc_uart_framer_if.slave   bus,
  output logic               uart_tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_TC = CW'(CLKS_PER_BIT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [1:0]    byte_idx, byte_nxt;
  logic [3:0]    bit_idx, bit_nxt;
  logic [CW-1:0] baud_cnt, baud_nxt;
  logic [15:0]   hold, hold_nxt;
  logic [7:0]    drop_lat, drop_lat_nxt;
  logic [7:0]    drop_cnt, drop_nxt;
  logic          tx_nxt;

  logic          baud_tc, bit_last, byte_last, frame_end;
  logic [7:0]    cur_byte;
  logic [3:0]    next_bit;
  logic [9:0]    char_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      byte_idx <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      hold     <= '0;
      drop_lat <= '0;
      drop_cnt <= '0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_nxt;
      byte_idx <= byte_nxt;
      bit_idx  <= bit_nxt;
      baud_cnt <= baud_nxt;
      hold     <= hold_nxt;
      drop_lat <= drop_lat_nxt;
      drop_cnt <= drop_nxt;
      uart_tx  <= tx_nxt;
    end
  end

  always_comb begin
    baud_tc   = (baud_cnt == BAUD_TC);
    bit_last  = (bit_idx == 4'd9);
    byte_last = (byte_idx == 2'd3);
    frame_end = baud_tc && bit_last && byte_last;
    next_bit  = 4'(bit_idx + 4'd1);
    case (byte_idx)
      2'd0:    cur_byte = SYNC_BYTE;
      2'd1:    cur_byte = hold[15:8];
      2'd2:    cur_byte = hold[7:0];
      default: cur_byte = drop_lat;
    endcase
    char_bits = {1'b1, cur_byte, 1'b0};
  end

  always_comb begin
    state_nxt    = state;
    byte_nxt     = byte_idx;
    bit_nxt      = bit_idx;
    baud_nxt     = baud_cnt;
    hold_nxt     = hold;
    drop_lat_nxt = drop_lat;
    drop_nxt     = drop_cnt;
    tx_nxt       = uart_tx;
    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (bus.meas_valid) begin
          hold_nxt     = bus.meas_data;
          drop_lat_nxt = drop_cnt;
          drop_nxt     = 8'd0;
          byte_nxt     = 2'd0;
          bit_nxt      = 4'd0;
          baud_nxt     = '0;
          tx_nxt       = 1'b0;
          state_nxt    = S_SEND;
        end
      end
      S_SEND: begin
        // A strobe coinciding with the frame's final edge is not counted,
        // giving 40*C-1 drops per frame under a continuous strobe.
        if (bus.meas_valid && !frame_end && drop_cnt != 8'hFF)
          drop_nxt = drop_cnt + 8'd1;
        if (baud_tc) begin
          baud_nxt = '0;
          if (bit_last) begin
            bit_nxt = 4'd0;
            if (byte_last) begin
              byte_nxt  = 2'd0;
              tx_nxt    = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              byte_nxt = 2'(byte_idx + 2'd1);
              tx_nxt   = 1'b0;
            end
          end else begin
            bit_nxt = next_bit;
            tx_nxt  = char_bits[next_bit];
          end
        end else begin
          baud_nxt = CW'(baud_cnt + 1'b1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.meas_ready = (state == S_IDLE);
  assign bus.busy       = (state == S_SEND);

endmodule
